fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC and issues word reads to the memory's read port.
- Captures the returned instruction, then hands the instruction and its PC to decode over a valid/ready handshake.
- Supports single-cycle redirects (branch/jump) that squash all fetched-but-undelivered work.

Parameters:
- W, 32, instruction/data width.
- D, 8, byte-address width; matches memory address width.
- RESET_PC, 0, byte address fetched first after reset; bits [1:0] must be 0.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous reset, active-low: 0 = reset asserted; removal is synchronous to i_clk upstream.
- o_mem_addr  out  D  byte address to memory; bits [1:0] always 0.
- o_mem_read  out  1  read enable to memory.
- i_mem_data  in  W  memory read data; valid the cycle after o_mem_read=1.
- i_redirect  in  1  one-cycle pulse: restart fetch at i_redirect_pc.
- i_redirect_pc  in  D  redirect target byte address.
- o_valid  out  1  o_instr/o_pc hold a valid fetched instruction.
- i_ready  in  1  decode accepts when o_valid and i_ready are both 1.
- o_instr  out  W  instruction word.
- o_pc  out  D  byte address of o_instr.

Behaviour:
- Memory contract: registered read with 1-cycle latency. i_mem_data holds its last value when read is not issued.
- State:
  - pc: next address to request.
  - req_valid: a read issued last cycle is returning now.
  - req_pc: address of that read.
  - Output register (out_valid/out_instr/out_pc) drives o_valid/o_instr/o_pc.
  - One-entry skid register (skid_valid/skid_instr/skid_pc).
- Reset (i_reset=0, immediate, asynchronous):
  - pc=RESET_PC; req_valid=0; out_valid=0; skid_valid=0.
  - o_instr=32'h00000013 (NOP); o_pc=RESET_PC; o_mem_read=0.
- Issue rule: o_mem_read=1 and o_mem_addr=pc when occupancy < 2 and i_redirect=0.
  - occupancy = out_valid + skid_valid + req_valid − (out_valid & i_ready).
  - On issue: pc<=pc+4, req_valid<=1, req_pc<=pc. Otherwise req_valid<=0.
- Response routing at each edge with req_valid=1 and no redirect:
  - If out register is empty or being accepted this cycle, it loads from skid first if skid_valid, else from i_mem_data/req_pc.
  - Any response not placed in the out register goes to skid.
  - Skid never overflows: the issue rule guarantees room.
  - Instruction order is preserved.
- Throughput: 1 instruction/cycle with i_ready held 1. First o_valid appears 2 cycles after the first issue.
- Redirect (i_redirect=1 at cycle t):
  - At the t edge: out_valid<=0, skid_valid<=0, req_valid<=0 (in-flight read squashed, its data ignored), pc<={i_redirect_pc[D-1:2],2'b00}.
  - No issue at t. Target fetched at t+1; target valid on o_valid at t+3.
- Redirect with o_valid & i_ready in the same cycle: redirect wins. The delivered instruction is younger than the redirect source, and decode discards it.
- Redirect has priority over all other events, including a full skid.
- Wrap-around: pc+4 is modulo 2^D (e.g. 8'hFC → 8'h00); no error.
- Back-pressure: o_valid/o_instr/o_pc stay stable while o_valid=1 and i_ready=0.
- Reset mid-operation: all in-flight/skid data discarded. The first issue after reset release is RESET_PC.

Decomposition:
- Shared package (riscv_pkg):
  - NOP_INSTR = 32'h00000013.
  - PC_STEP = 4.
  - Default W/D constants, shared with memory.
- Sub-module fetch_skid_buffer: out register plus one-entry skid, with flush input and a valid/ready on both sides; 2-entry capacity. fetch_unit keeps the PC/issue/credit logic.

Test Plan:
- Memory preloaded mem[k]=32'h1000_0000+k, i_ready=1, reset released → o_mem_read asserted on the first cycle after release with addr 8'h00. o_valid rises 2 cycles later with o_instr=32'h1000_0000/o_pc=8'h00, then 32'h1000_0001/8'h04 each cycle.
- Hold i_ready=0 for 5 cycles mid-stream → o_instr/o_pc frozen, at most 2 reads outstanding past the held word, o_mem_read=0 afterward. On i_ready=1, words resume in order with no gaps or duplicates.
- Pulse i_redirect with i_redirect_pc=8'h41 while skid full → o_valid=0 next cycle. Fetch addr 8'h40 issued at t+1; o_instr=32'h1000_0010, o_pc=8'h40 at t+3. No stale words appear.
- Run from pc=8'hF8 with i_ready=1 → sequence 8'hF8, 8'hFC, 8'h00, 8'h04 with matching data.
- Assert i_reset=0 mid-stream, asynchronous to the clock edge → o_valid=0 and o_instr=32'h00000013 immediately. After release, restart at RESET_PC.
- Redirect coincident with o_valid&i_ready → next delivered o_pc is the redirect target. Memory sees exactly one read of the target.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg: constants shared by the fetch stage and the instruction memory.
package riscv_pkg;
  localparam int          DEF_W     = 32;
  localparam int          DEF_D     = 8;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// fetch_skid_buffer: output register plus one-entry skid (2-entry capacity), in-order, with flush.
// Revision: 1.0
module fetch_skid_buffer
  import riscv_pkg::*;
#(
  parameter int             W        = DEF_W,
  parameter int             D        = DEF_D,
  parameter logic [D-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_instr,
  input  logic [D-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_instr,
  output logic [D-1:0] out_pc,
  output logic [1:0]   level
);

  logic         skid_valid;
  logic [W-1:0] skid_instr;
  logic [D-1:0] skid_pc;
  logic         accept;

  assign accept   = out_valid & out_ready;
  // Entries still held after this edge if nothing new arrives.
  assign level    = {1'b0, out_valid} + {1'b0, skid_valid} - {1'b0, accept};
  assign in_ready = (level != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_instr  <= W'(NOP_INSTR);
      out_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= W'(NOP_INSTR);
      skid_pc    <= RESET_PC;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_instr <= in_instr;
          skid_pc    <= in_pc;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_instr <= in_instr;
          out_pc    <= in_pc;
        end
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: PC owner and read issuer for instruction memory; delivers instr/pc to decode via valid/ready.
// Revision: 1.0
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int           W        = DEF_W,
  parameter int           D        = DEF_D,
  parameter logic [D-1:0] RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic [D-1:0] o_mem_addr,
  output logic         o_mem_read,
  input  logic [W-1:0] i_mem_data,
  input  logic         i_redirect,
  input  logic [D-1:0] i_redirect_pc,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_instr,
  output logic [D-1:0] o_pc
);

  localparam logic [D-1:0] STEP = D'(PC_STEP);

  logic [D-1:0] pc;
  logic [D-1:0] req_pc;
  logic         req_valid;
  logic [1:0]   level;
  logic         buf_in_ready;
  logic         room;
  logic         issue;

  // Occupancy (buffered + in flight) must stay below 2 so the skid never overflows.
  assign room  = req_valid ? (level == 2'd0) : buf_in_ready;
  assign issue = i_reset && !i_redirect && room;

  assign o_mem_read = issue;
  assign o_mem_addr = {pc[D-1:2], 2'b00};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      req_valid <= 1'b0;
    end else if (i_redirect) begin
      pc        <= {i_redirect_pc[D-1:2], 2'b00};
      req_valid <= 1'b0;
    end else begin
      req_valid <= issue;
      if (issue) begin
        pc     <= pc + STEP;
        req_pc <= pc;
      end
    end
  end

  fetch_skid_buffer #(
    .W        (W),
    .D        (D),
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .flush     (i_redirect),
    .in_valid  (req_valid && !i_redirect),
    .in_ready  (buf_in_ready),
    .in_instr  (i_mem_data),
    .in_pc     (req_pc),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_instr (o_instr),
    .out_pc    (o_pc),
    .level     (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: startup vector table, delivery scoreboard, and hand-written back-pressure/redirect/wrap/reset sequences.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic [D-1:0] mem_addr;
  logic         mem_read;
  logic [W-1:0] mem_data    = '0;
  logic         redirect    = 1'b0;
  logic [D-1:0] redirect_pc = '0;
  logic         valid;
  logic         ready       = 1'b0;
  logic [W-1:0] instr;
  logic [D-1:0] pc;

  fetch_unit dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .o_mem_addr    (mem_addr),
    .o_mem_read    (mem_read),
    .i_mem_data    (mem_data),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [64];
  initial for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
  always @(posedge clk) if (mem_read) mem_data <= mem[mem_addr[7:2]];

  typedef struct {
    logic [D-1:0] pc;
    logic [W-1:0] instr;
  } exp_t;

  typedef struct {
    logic         rdy;
    logic         exp_read;
    logic [D-1:0] exp_addr;
    logic         exp_valid;
    logic [D-1:0] exp_pc;
    logic [W-1:0] exp_instr;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[6];
  int           compared    = 0;
  int           mismatched  = 0;
  int           watch_reads = 0;
  logic [D-1:0] watch_addr  = '0;

  function automatic logic [W-1:0] word_at(input logic [D-1:0] a);
    return 32'h1000_0000 + W'(a >> 2);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [D-1:0] start, input int n);
    logic [D-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: a, instr: word_at(a)});
      a = a + 8'd4;
    end
  endtask

  // Called at posedge+1: drive inputs, let outputs settle, then monitor reads and deliveries.
  task automatic drive(input logic rdy, input logic redir, input logic [D-1:0] rpc);
    exp_t e;
    ready       = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #2;
    if (mem_read && mem_addr == watch_addr) watch_reads++;
    if (valid && rdy && !redir) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_extra: got delivery pc %h, expected none", pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", W'(pc), W'(e.pc));
        check("sb_instr", instr, e.instr);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      drive(1'b1, 1'b0, '0);
      tick();
      n++;
    end
    check("sb_drained", W'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 8'h04, 1'b0, 8'h00, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h00, 32'h1000_0000};
    vecs[3] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h04, 32'h1000_0001};
    vecs[4] = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h08, 32'h1000_0002};
    vecs[5] = '{1'b1, 1'b1, 8'h14, 1'b1, 8'h0C, 32'h1000_0003};

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instr, W'(NOP_INSTR));
    check("rst_pc", W'(pc), 32'h0);
    check("rst_read", mem_read, 1'b0);
    rst_n = 1'b1;

    // Startup and steady streaming.
    expect_seq(8'h00, 16);
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rdy, 1'b0, '0);
      check("vec_read", mem_read, vecs[i].exp_read);
      check("vec_addr", W'(mem_addr), W'(vecs[i].exp_addr));
      check("vec_valid", valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("vec_pc", W'(pc), W'(vecs[i].exp_pc));
        check("vec_instr", instr, vecs[i].exp_instr);
      end
      tick();
    end
    repeat (2) begin
      drive(1'b1, 1'b0, '0);
      tick();
    end

    // Back-pressure: output frozen on the oldest undelivered word, no new reads.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0);
      check("hold_valid", valid, 1'b1);
      check("hold_pc", W'(pc), W'(sb[0].pc));
      check("hold_instr", instr, sb[0].instr);
      check("hold_no_read", mem_read, 1'b0);
      tick();
    end
    run_drain(64);

    // Fill the skid, then redirect to a misaligned target.
    repeat (2) begin
      drive(1'b0, 1'b0, '0);
      tick();
    end
    sb.delete();
    expect_seq(8'h40, 6);
    watch_addr  = 8'h40;
    watch_reads = 0;
    drive(1'b0, 1'b1, 8'h41);
    check("redir_t0_read", mem_read, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0);
    check("redir_t1_valid", valid, 1'b0);
    check("redir_t1_read", mem_read, 1'b1);
    check("redir_t1_addr", W'(mem_addr), 32'h40);
    tick();
    drive(1'b1, 1'b0, '0);
    check("redir_t2_valid", valid, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0);
    check("redir_t3_valid", valid, 1'b1);
    tick();
    run_drain(64);
    check("redir_target_reads", W'(watch_reads), 32'd1);

    // Redirect coincident with a handshake, target near the top so the PC wraps.
    sb.delete();
    expect_seq(8'hF8, 6);
    watch_addr  = 8'hF8;
    watch_reads = 0;
    drive(1'b1, 1'b1, 8'hF8);
    check("coincident_valid", valid, 1'b1);
    tick();
    run_drain(64);
    check("wrap_target_reads", W'(watch_reads), 32'd1);

    // Asynchronous reset mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 1'b0);
    check("arst_instr", instr, W'(NOP_INSTR));
    check("arst_pc", W'(pc), 32'h0);
    check("arst_read", mem_read, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
    expect_seq(8'h00, 4);
    drive(1'b1, 1'b0, '0);
    check("restart_read", mem_read, 1'b1);
    check("restart_addr", W'(mem_addr), 32'h0);
    tick();
    run_drain(32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
